instr_fetch_unit: RTL and testbench

Instruction fetch stage sitting directly upstream of the instruction block RAM. It owns the program counter, drives the BRAM read port (RD_ADDR/RE), and pairs each returned word (DO/DO_VALID, one-cycle read latency) with its PC. Fetched instructions go into a 2-entry buffer and are presented to decode over a valid/ready handshake. Branch/jump redirects from execute flush the buffer and discard any read still in flight.

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/fetch_buf.sv | 64 ++++++
 rtl/instr_fetch_unit.sv | 94 +++++++++
 tb/tb_instr_fetch_unit.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int XLEN            = 32;
    localparam int ILEN            = 32;
    localparam int INSTR_BYTES     = 4;
    localparam int FETCH_BUF_DEPTH = 2;
    localparam int FETCH_BUF_PTR_W = $clog2(FETCH_BUF_DEPTH);

    // One buffered instruction together with the byte PC it was fetched from.
    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    // Force a byte address onto an instruction boundary.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

    // Sequential successor of a fetch PC; wraps naturally at 2^XLEN.
    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] addr);
        return addr + XLEN'(INSTR_BYTES);
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// Small synchronous FIFO holding fetched instructions until decode takes them.
// Flush wins over push and pop in the same cycle.
module fetch_buf
    import fetch_pkg::*;
(
    input  logic         CLK,
    input  logic         RST,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head_entry,
    output logic         head_valid,
    output logic [1:0]   occ
);

    fetch_entry_t               entries [FETCH_BUF_DEPTH];
    logic [FETCH_BUF_PTR_W-1:0] wr_ptr;
    logic [FETCH_BUF_PTR_W-1:0] rd_ptr;
    logic [1:0]                 count;
    logic                       do_push;
    logic                       do_pop;

    // Guard against misuse: never pop empty, never overwrite a live entry.
    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'(FETCH_BUF_DEPTH)) || do_pop);

    // Pointer and occupancy bookkeeping.
    // NOTE: state registers use non-blocking assignments so every always_ff
    // samples the pre-edge values of its peers, whatever the evaluation order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    // Entry storage; written only on a push.
    // NOTE: storage is normally left unreset, but this buffer is two entries
    // and the head must read as zero straight out of reset, so it is cleared.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < FETCH_BUF_DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (do_push && !flush) begin
            entries[wr_ptr] <= push_entry;
        end
    end

    assign head_entry = entries[rd_ptr];
    assign head_valid = (count != 2'd0);
    assign occ        = count;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the BRAM read port, pairs each
// returned word with its PC and hands it to decode through a 2-entry buffer.
// Redirects from execute flush the buffer and drop any read still in flight.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int              ADDR_WIDTH = 10,
    parameter int              DATA_WIDTH = 32,
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                  CLK,
    input  logic                  RST,
    output logic [ADDR_WIDTH-1:0] RD_ADDR,
    output logic                  RE,
    input  logic [DATA_WIDTH-1:0] DO,
    input  logic                  DO_VALID,
    input  logic                  REDIRECT_VALID,
    input  logic [XLEN-1:0]       REDIRECT_PC,
    output logic                  INSTR_VALID,
    output logic [DATA_WIDTH-1:0] INSTR,
    output logic [XLEN-1:0]       INSTR_PC,
    input  logic                  INSTR_READY
);

    logic [XLEN-1:0] pc;
    logic            inf;
    logic [XLEN-1:0] inf_pc;
    logic [1:0]      occ;
    logic            fire;
    logic            issue;
    logic            push;
    logic [2:0]      credit_used;
    fetch_entry_t    push_entry;
    fetch_entry_t    head_entry;
    logic            head_valid;

    assign fire = head_valid && INSTR_READY;

    // Credit check: buffered + in-flight words, less the one leaving this
    // cycle, must leave room for the word this cycle's read will return.
    // Reset gates the read so RE is 0 while RST is held.
    // NOTE: every signal written here gets a default first; a path that left
    // one unassigned would infer a latch.
    always_comb begin
        credit_used = 3'd0;
        issue       = 1'b0;
        credit_used = {1'b0, occ} + {2'b00, inf} - {2'b00, fire};
        issue       = !RST && !REDIRECT_VALID && (credit_used < 3'(FETCH_BUF_DEPTH));
    end

    assign RE      = issue;
    assign RD_ADDR = pc[ADDR_WIDTH+1:2];

    // A returned word is kept only if its read is still wanted: a redirect in
    // the same cycle, or a reset since the read, discards it.
    assign push             = DO_VALID && inf && !REDIRECT_VALID;
    assign push_entry.instr = DO;
    assign push_entry.pc    = inf_pc;

    // PC and in-flight tracking; redirect overrides sequential fetch.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc     <= align_pc(RESET_PC);
            inf    <= 1'b0;
            inf_pc <= '0;
        end else if (REDIRECT_VALID) begin
            pc  <= align_pc(REDIRECT_PC);
            inf <= 1'b0;
        end else if (issue) begin
            pc     <= next_pc(pc);
            inf    <= 1'b1;
            inf_pc <= pc;
        end else begin
            inf <= 1'b0;
        end
    end

    fetch_buf u_fetch_buf (
        .CLK        (CLK),
        .RST        (RST),
        .push       (push),
        .push_entry (push_entry),
        .pop        (fire),
        .flush      (REDIRECT_VALID),
        .head_entry (head_entry),
        .head_valid (head_valid),
        .occ        (occ)
    );

    assign INSTR_VALID = head_valid;
    assign INSTR       = head_entry.instr;
    assign INSTR_PC    = head_entry.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: behavioural BRAM with one-cycle read latency,
// a queue of expected PCs filled as stimulus is planned, and per-scenario tasks.
module tb_instr_fetch_unit;

    localparam int          AW  = 10;
    localparam int          DW  = 32;
    localparam logic [31:0] RPC = 32'h0000_0100;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] rd_addr;
    logic          re;
    logic [DW-1:0] dut_do;
    logic          do_valid;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          instr_valid;
    logic [DW-1:0] instr;
    logic [31:0]   instr_pc;
    logic          instr_ready;

    logic [DW-1:0] bram_do    = '0;
    logic          bram_valid = 1'b0;
    logic          stray_dv;

    int            checks = 0;
    int            errors = 0;
    logic [31:0]   exp_q[$];

    logic          last_fire;
    logic          last_valid;
    logic          last_re;
    logic [AW-1:0] last_rd_addr;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .RESET_PC   (RPC)
    ) dut (
        .CLK            (clk),
        .RST            (rst),
        .RD_ADDR        (rd_addr),
        .RE             (re),
        .DO             (dut_do),
        .DO_VALID       (do_valid),
        .REDIRECT_VALID (redirect_valid),
        .REDIRECT_PC    (redirect_pc),
        .INSTR_VALID    (instr_valid),
        .INSTR          (instr),
        .INSTR_PC       (instr_pc),
        .INSTR_READY    (instr_ready)
    );

    // BRAM contents: each word encodes its own word address.
    function automatic logic [DW-1:0] word_at(input logic [AW-1:0] a);
        return 32'hC0DE_0000 | {22'd0, a};
    endfunction

    always @(posedge clk) begin
        bram_do    <= word_at(rd_addr);
        bram_valid <= re;
    end

    assign dut_do   = stray_dv ? 32'hDEAD_BEEF : bram_do;
    assign do_valid = bram_valid | stray_dv;

    // One clock: drive inputs at negedge, observe 1ns later, score any fire.
    // Decode is ready only while the scoreboard still expects instructions.
    task automatic cycle(input logic redir, input logic [31:0] rpc,
                         input logic stray, input logic hold);
        logic [31:0] e;
        @(negedge clk);
        redirect_valid = redir;
        redirect_pc    = rpc;
        stray_dv       = stray;
        instr_ready    = !hold && (exp_q.size() != 0);
        #1;
        last_re      = re;
        last_rd_addr = rd_addr;
        last_valid   = instr_valid;
        last_fire    = instr_valid && instr_ready;
        if (last_fire) begin
            e = exp_q.pop_front();
            checks++;
            if (instr_pc !== e) begin
                errors++;
                $display("FAIL sb_pc got %h exp %h", instr_pc, e);
            end
            checks++;
            if (instr !== word_at(e[11:2])) begin
                errors++;
                $display("FAIL sb_data pc %h got %h exp %h", e, instr, word_at(e[11:2]));
            end
        end
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checks++; if (re !== 1'b0) begin errors++; $display("FAIL rst_re got %b exp 0", re); end
        checks++; if (rd_addr !== 10'h040) begin errors++; $display("FAIL rst_rd_addr got %h exp 040", rd_addr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", instr_valid); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL rst_instr got %h exp 0", instr); end
        checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL rst_instr_pc got %h exp 0", instr_pc); end
    endtask

    task automatic test_stream();
        int first_valid = -1;
        int first_fire  = -1;
        int last_at     = -1;
        exp_q.delete();
        for (int k = 0; k < 4; k++) exp_q.push_back(RPC + 32'(4 * k));
        @(posedge clk);
        #2 rst = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b0);
            if (i == 0) begin
                checks++; if (last_re !== 1'b1) begin errors++; $display("FAIL stream_first_re got %b exp 1", last_re); end
                checks++; if (last_rd_addr !== 10'h040) begin errors++; $display("FAIL stream_first_addr got %h exp 040", last_rd_addr); end
            end
            if (last_valid && first_valid < 0) first_valid = i;
            if (last_fire) begin
                if (first_fire < 0) first_fire = i;
                last_at = i;
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stream_timeout left %0d exp 0", exp_q.size()); end
        checks++; if (first_valid != 2) begin errors++; $display("FAIL stream_latency got %0d exp 2", first_valid); end
        checks++; if (last_at - first_fire != 3) begin errors++; $display("FAIL stream_rate span %0d exp 3", last_at - first_fire); end
    endtask

    task automatic test_stall();
        int fires = 0;
        int n     = 0;
        exp_q.delete();
        for (int k = 0; k < 8; k++) exp_q.push_back(32'h110 + 32'(4 * k));
        for (int i = 0; i < 20 && fires < 3; i++) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b0);
            if (last_fire) fires++;
        end
        checks++; if (fires != 3) begin errors++; $display("FAIL stall_prefix fires %0d exp 3", fires); end
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b1);
            checks++; if (last_re !== 1'b0) begin errors++; $display("FAIL stall_re cyc %0d got %b exp 0", i, last_re); end
        end
        checks++; if (last_valid !== 1'b1) begin errors++; $display("FAIL stall_valid got %b exp 1", last_valid); end
        while (exp_q.size() != 0 && n < 20) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b0);
            if (n == 0) begin
                checks++; if (last_re !== 1'b1) begin errors++; $display("FAIL stall_reissue got %b exp 1", last_re); end
            end
            checks++; if (last_fire !== 1'b1) begin errors++; $display("FAIL stall_bubble cyc %0d got %b exp 1", n, last_fire); end
            n++;
        end
        checks++; if (n != 5) begin errors++; $display("FAIL stall_drain cycles %0d exp 5", n); end
    endtask

    task automatic test_redirect_full();
        int first_valid = -1;
        settle(3);
        checks++; if (last_valid !== 1'b1 || last_re !== 1'b0) begin errors++; $display("FAIL redir_pre valid %b re %b exp 1 0", last_valid, last_re); end
        cycle(1'b1, 32'h0000_0203, 1'b0, 1'b0);
        checks++; if (last_re !== 1'b0) begin errors++; $display("FAIL redir_re got %b exp 0", last_re); end
        exp_q.push_back(32'h200);
        exp_q.push_back(32'h204);
        for (int j = 1; j < 20 && exp_q.size() != 0; j++) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b0);
            if (j == 1) begin
                checks++; if (last_re !== 1'b1 || last_rd_addr !== 10'h080) begin errors++; $display("FAIL redir_target re %b addr %h exp 1 080", last_re, last_rd_addr); end
            end
            if (last_valid && first_valid < 0) first_valid = j;
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL redir_timeout left %0d exp 0", exp_q.size()); end
        checks++; if (first_valid != 3) begin errors++; $display("FAIL redir_penalty got %0d exp 3", first_valid); end
    endtask

    task automatic test_redirect_fire();
        int first_valid = -1;
        settle(3);
        exp_q.push_back(32'h208);
        exp_q.push_back(32'h20C);
        exp_q.push_back(32'h210);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b1, 32'h0000_0404, 1'b0, 1'b0);
        checks++; if (last_fire !== 1'b1) begin errors++; $display("FAIL rfire_fire got %b exp 1", last_fire); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rfire_consumed left %0d exp 0", exp_q.size()); end
        exp_q.delete();
        exp_q.push_back(32'h404);
        exp_q.push_back(32'h408);
        for (int j = 1; j < 20 && exp_q.size() != 0; j++) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b0);
            if (last_valid && first_valid < 0) first_valid = j;
        end
        checks++; if (first_valid != 3) begin errors++; $display("FAIL rfire_penalty got %0d exp 3", first_valid); end
    endtask

    task automatic test_wrap();
        settle(3);
        cycle(1'b1, 32'h0000_0FF8, 1'b0, 1'b0);
        exp_q.delete();
        exp_q.push_back(32'hFF8);
        exp_q.push_back(32'hFFC);
        exp_q.push_back(32'h1000);
        exp_q.push_back(32'h1004);
        for (int j = 1; j < 20 && exp_q.size() != 0; j++) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b0);
            if (j == 2) begin
                checks++; if (last_rd_addr !== 10'h3FF) begin errors++; $display("FAIL wrap_last got %h exp 3ff", last_rd_addr); end
            end
            if (j == 3) begin
                checks++; if (last_re !== 1'b1 || last_rd_addr !== 10'h000) begin errors++; $display("FAIL wrap_zero re %b addr %h exp 1 000", last_re, last_rd_addr); end
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_timeout left %0d exp 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        int first_valid = -1;
        settle(3);
        cycle(1'b1, 32'h0000_0500, 1'b0, 1'b0);
        exp_q.delete();
        for (int k = 0; k < 4; k++) exp_q.push_back(32'h500 + 32'(4 * k));
        for (int j = 0; j < 20 && exp_q.size() > 2; j++) cycle(1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (exp_q.size() != 2) begin errors++; $display("FAIL mid_prefix left %0d exp 2", exp_q.size()); end
        @(negedge clk);
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        stray_dv       = 1'b0;
        #1 rst = 1'b1;
        #1;
        checks++; if (re !== 1'b0) begin errors++; $display("FAIL mid_re got %b exp 0", re); end
        checks++; if (rd_addr !== 10'h040) begin errors++; $display("FAIL mid_addr got %h exp 040", rd_addr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b exp 0", instr_valid); end
        checks++; if (instr !== 32'h0 || instr_pc !== 32'h0) begin errors++; $display("FAIL mid_head got %h/%h exp 0/0", instr, instr_pc); end
        exp_q.delete();
        @(posedge clk);
        #2 rst = 1'b0;
        exp_q.push_back(RPC);
        exp_q.push_back(RPC + 32'h4);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            cycle(1'b0, 32'h0, (i == 0), 1'b0);
            if (i == 0) begin
                checks++; if (last_re !== 1'b1) begin errors++; $display("FAIL mid_restart_re got %b exp 1", last_re); end
            end
            if (last_valid && first_valid < 0) first_valid = i;
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL mid_timeout left %0d exp 0", exp_q.size()); end
        checks++; if (first_valid != 2) begin errors++; $display("FAIL mid_latency got %0d exp 2", first_valid); end
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = 1'b0;
        stray_dv       = 1'b0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_full();
        test_redirect_fire();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
